perf_timer_bank: RTL and testbench
==================================

Name: perf_timer_bank

Overview:
Multi-channel cycle/tick timer bank that measures start-to-stop intervals on NUM_CH independent channels. Each channel keeps last, min and max interval, run count and sticky overflow statistics. A channel-select read port exposes the statistics. It is used to profile pipeline stages (pyramid build, DoG, keypoint detect, descriptor) concurrently in one build.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 32, width of interval counter and last/min/max registers
TICK_DIV, 1, clock cycles per counted tick (1 = raw cycles; 50 = 1 us at 50 MHz)
RUN_W, 16, width of per-channel run counter
RESTART_ON_START, 0, 0: start while running is ignored; 1: start while running restarts the measurement with no capture

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active high
start  input  NUM_CH  per-channel start pulse, active high
stop  input  NUM_CH  per-channel stop pulse, active high
clr  input  NUM_CH  per-channel statistics clear, active high
busy  output  NUM_CH  channel running
done  output  NUM_CH  one-cycle pulse, the cycle after a capture
rd_sel  input  clogb2(NUM_CH)  channel select for read port
rd_last  output  CNT_W  last captured interval, in ticks
rd_min  output  CNT_W  minimum captured interval
rd_max  output  CNT_W  maximum captured interval
rd_runs  output  RUN_W  number of captures since clear, saturating
rd_ovf  output  1  sticky: some capture since clear saturated

Behaviour:
- Per-channel states: IDLE, RUN. busy = (state==RUN).
- Reset (rst=1 at clk edge): all channels IDLE; cnt=0, sub=0, last=0, min=all-ones, max=0, runs=0, ovf=0, done=0.
- clr[i] takes the same action as reset, for channel i only. Its priority is rst > clr > stop > start.
- IDLE & start: go to RUN; cnt<=0, sub<=0, meas_ovf<=0. A stop in the same cycle is ignored.
- RUN, every cycle including the stop cycle:
  - sub increments.
  - When sub==TICK_DIV-1: sub<=0 and cnt increments, saturating at 2^CNT_W-1. Saturation sets meas_ovf.
- RUN & stop: capture. cap = cnt value after this cycle's update, so the interval equals floor((T_stop - T_start)/TICK_DIV) ticks.
  - last<=cap; min<=min(min,cap); max<=max(max,cap).
  - runs<=runs+1, saturating at 2^RUN_W-1.
  - ovf<=ovf|meas_ovf_next.
  - Go to IDLE. done[i]=1 in the next cycle only.
- RUN & start & stop in the same cycle: stop wins (capture, IDLE). The start is dropped.
- RUN & start only:
  - RESTART_ON_START=0: ignored.
  - RESTART_ON_START=1: cnt<=0, sub<=0, meas_ovf<=0; stays RUN; no capture, no done.
- IDLE & stop: ignored; no statistic changes.
- The first capture after a clear sets min=max=cap, because of the init values.
- A saturated capture stores all-ones into last/max and participates in min.
- Read port is combinational from registered statistics.
  - rd_sel >= NUM_CH returns all zeros.
  - A value captured at edge E is visible on rd_* after E, in the same cycle done pulses.
- Channels are fully independent; simultaneous events on different channels never interact.
- cnt and sub are internal. Width of sub = clogb2(TICK_DIV); with TICK_DIV=1 every RUN cycle is one tick.

Test Plan:
- TICK_DIV=1: start[0] at cycle 10, stop[0] at cycle 25 -> done[0] at cycle 26; rd_last=15, rd_min=15, rd_max=15, rd_runs=1, busy[0] high during cycles 11..25.
- Channel 1 three runs of 7, 3, 12 cycles -> rd_last=12, rd_min=3, rd_max=12, rd_runs=3; channels 0, 2, 3 unchanged.
- TICK_DIV=50: interval 149 cycles -> rd_last=2; interval 150 cycles -> rd_last=3.
- CNT_W=4, interval 20 cycles -> rd_last=15, rd_ovf=1; clr[0] then a 5-cycle run -> rd_ovf=0, rd_last=5, rd_min=5, rd_runs=1.
- RESTART_ON_START=1:
  - start at 0, start at 8, stop at 12 -> rd_last=4, rd_runs=1.
  - With RESTART_ON_START=0, the same stimulus -> rd_last=12.
- Boundary cases:
  - start & stop together while IDLE -> channel enters RUN, no capture.
  - stop while IDLE -> no change.
  - rst asserted mid-RUN -> busy=0, all statistics at reset values, no done pulse.

Source files
------------

// File: rtl/perf_timer_bank_if.sv
// perf_timer_bank bus: per-channel controls,
// status and the channel-select statistics port.
interface perf_timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int RUN_W  = 16
);
  localparam int SEL_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_last;
  logic [CNT_W-1:0]  rd_min;
  logic [CNT_W-1:0]  rd_max;
  logic [RUN_W-1:0]  rd_runs;
  logic              rd_ovf;

  modport master (
    output start, stop, clr, rd_sel,
    input  busy, done, rd_last, rd_min,
    input  rd_max, rd_runs, rd_ovf
  );

  modport slave (
    input  start, stop, clr, rd_sel,
    output busy, done, rd_last, rd_min,
    output rd_max, rd_runs, rd_ovf
  );
endinterface

// File: rtl/perf_timer_bank.sv
// Multi-channel start/stop interval timer bank
// with last/min/max/run-count/overflow statistics.
module perf_timer_bank #(
  parameter int NUM_CH           = 4,
  parameter int CNT_W            = 32,
  parameter int TICK_DIV         = 1,
  parameter int RUN_W            = 16,
  parameter int RESTART_ON_START = 0
) (
  input logic              clk,
  input logic              rst,
  perf_timer_bank_if.slave bus
);
  localparam int SUB_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST =
    SUB_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic { IDLE, RUN } st_t;

  logic [NUM_CH*CNT_W-1:0] last_v;
  logic [NUM_CH*CNT_W-1:0] min_v;
  logic [NUM_CH*CNT_W-1:0] max_v;
  logic [NUM_CH*RUN_W-1:0] runs_v;
  logic [NUM_CH-1:0]       ovf_v;
  logic [NUM_CH-1:0]       busy_v;
  logic [NUM_CH-1:0]       done_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    st_t              st_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUB_W-1:0] sub_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] mn_q;
    logic [CNT_W-1:0] mx_q;
    logic [RUN_W-1:0] runs_q;
    logic             mov_q;
    logic             ovf_q;
    logic             dn_q;

    logic             tick;
    logic [SUB_W-1:0] sub_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             mov_nx;
    logic             rstrt;

    // Next counter values for a RUN cycle.
    always_comb begin
      tick   = (sub_q == SUB_LAST);
      sub_nx = tick ? '0 : sub_q + SUB_W'(1);
      cnt_nx = cnt_q;
      mov_nx = mov_q;
      if (tick) begin
        if (cnt_q == CNT_MAX) mov_nx = 1'b1;
        else cnt_nx = cnt_q + CNT_W'(1);
      end
      rstrt = (RESTART_ON_START != 0) &&
              bus.start[i] && !bus.stop[i];
    end

    // Channel FSM with capture and statistics.
    always_ff @(posedge clk) begin
      if (rst || bus.clr[i]) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        sub_q  <= '0;
        last_q <= '0;
        mn_q   <= CNT_MAX;
        mx_q   <= '0;
        runs_q <= '0;
        mov_q  <= 1'b0;
        ovf_q  <= 1'b0;
        dn_q   <= 1'b0;
      end else begin
        dn_q <= 1'b0;
        unique case (st_q)
          IDLE: begin
            if (bus.start[i]) begin
              st_q  <= RUN;
              cnt_q <= '0;
              sub_q <= '0;
              mov_q <= 1'b0;
            end
          end
          RUN: begin
            unique case (1'b1)
              bus.stop[i]: begin
                st_q   <= IDLE;
                dn_q   <= 1'b1;
                cnt_q  <= cnt_nx;
                sub_q  <= sub_nx;
                mov_q  <= mov_nx;
                last_q <= cnt_nx;
                if (cnt_nx < mn_q) mn_q <= cnt_nx;
                if (cnt_nx > mx_q) mx_q <= cnt_nx;
                if (runs_q != RUN_MAX)
                  runs_q <= runs_q + RUN_W'(1);
                ovf_q <= ovf_q | mov_nx;
              end
              rstrt: begin
                cnt_q <= '0;
                sub_q <= '0;
                mov_q <= 1'b0;
              end
              default: begin
                cnt_q <= cnt_nx;
                sub_q <= sub_nx;
                mov_q <= mov_nx;
              end
            endcase
          end
          default: st_q <= IDLE;
        endcase
      end
    end

    assign busy_v[i] = (st_q == RUN);
    assign done_v[i] = dn_q;
    assign ovf_v[i]  = ovf_q;
    assign last_v[i*CNT_W +: CNT_W] = last_q;
    assign min_v[i*CNT_W +: CNT_W]  = mn_q;
    assign max_v[i*CNT_W +: CNT_W]  = mx_q;
    assign runs_v[i*RUN_W +: RUN_W] = runs_q;
  end

  assign bus.busy = busy_v;
  assign bus.done = done_v;

  // Read port: out-of-range select reads zero.
  always_comb begin
    int sel;
    sel         = int'(bus.rd_sel);
    bus.rd_last = '0;
    bus.rd_min  = '0;
    bus.rd_max  = '0;
    bus.rd_runs = '0;
    bus.rd_ovf  = 1'b0;
    if (sel < NUM_CH) begin
      bus.rd_last = last_v[sel*CNT_W +: CNT_W];
      bus.rd_min  = min_v[sel*CNT_W +: CNT_W];
      bus.rd_max  = max_v[sel*CNT_W +: CNT_W];
      bus.rd_runs = runs_v[sel*RUN_W +: RUN_W];
      bus.rd_ovf  = ovf_v[sel];
    end
  end
endmodule

// File: tb/tb_perf_timer_bank.sv
// Directed bench for perf_timer_bank: four
// instances cover tick divide, saturation, restart.
module tb_perf_timer_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  perf_timer_bank_if #(.NUM_CH(4), .CNT_W(32), .RUN_W(16)) aif ();
  perf_timer_bank_if #(.NUM_CH(4), .CNT_W(32), .RUN_W(16)) bif ();
  perf_timer_bank_if #(.NUM_CH(4), .CNT_W(4),  .RUN_W(16)) cif ();
  perf_timer_bank_if #(.NUM_CH(4), .CNT_W(32), .RUN_W(16)) dif ();

  perf_timer_bank #(.NUM_CH(4), .CNT_W(32), .TICK_DIV(1),
    .RUN_W(16), .RESTART_ON_START(0))
    u_a (.clk(clk), .rst(rst), .bus(aif.slave));
  perf_timer_bank #(.NUM_CH(4), .CNT_W(32), .TICK_DIV(50),
    .RUN_W(16), .RESTART_ON_START(0))
    u_b (.clk(clk), .rst(rst), .bus(bif.slave));
  perf_timer_bank #(.NUM_CH(4), .CNT_W(4), .TICK_DIV(1),
    .RUN_W(16), .RESTART_ON_START(0))
    u_c (.clk(clk), .rst(rst), .bus(cif.slave));
  perf_timer_bank #(.NUM_CH(4), .CNT_W(32), .TICK_DIV(1),
    .RUN_W(16), .RESTART_ON_START(1))
    u_d (.clk(clk), .rst(rst), .bus(dif.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_run(input int ch, input int n);
    aif.start[ch] = 1'b1;
    step();
    aif.start[ch] = 1'b0;
    repeat (n - 1) step();
    aif.stop[ch] = 1'b1;
    step();
    aif.stop[ch] = 1'b0;
  endtask

  task automatic b_run(input int n);
    bif.start[0] = 1'b1;
    step();
    bif.start[0] = 1'b0;
    repeat (n - 1) step();
    bif.stop[0] = 1'b1;
    step();
    bif.stop[0] = 1'b0;
  endtask

  task automatic c_run(input int n);
    cif.start[0] = 1'b1;
    step();
    cif.start[0] = 1'b0;
    repeat (n - 1) step();
    cif.stop[0] = 1'b1;
    step();
    cif.stop[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    aif.rd_sel = 2'd0;
    #1;
    checks++;
    if (aif.busy !== 4'b0000) begin
      errors++;
      $display("FAIL rst_busy got %b want 0000", aif.busy);
    end
    checks++;
    if (aif.done !== 4'b0000) begin
      errors++;
      $display("FAIL rst_done got %b want 0000", aif.done);
    end
    checks++;
    if (aif.rd_min !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rst_min got %h want ffffffff", aif.rd_min);
    end
    checks++;
    if (aif.rd_last !== 32'd0 || aif.rd_max !== 32'd0 ||
        aif.rd_runs !== 16'd0 || aif.rd_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_stats got last=%0d max=%0d runs=%0d ovf=%b want 0 0 0 0",
        aif.rd_last, aif.rd_max, aif.rd_runs, aif.rd_ovf);
    end
  endtask

  task automatic test_single();
    int bad;
    bad = 0;
    aif.start[0] = 1'b1;
    step();
    aif.start[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (aif.busy[0] !== 1'b1 || aif.done[0] !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_busy got %0d bad cycles want 0", bad);
    end
    aif.stop[0] = 1'b1;
    step();
    aif.stop[0] = 1'b0;
    aif.rd_sel = 2'd0;
    #1;
    checks++;
    if (aif.done[0] !== 1'b1 || aif.busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done got done=%b busy=%b want 1 0",
        aif.done[0], aif.busy[0]);
    end
    checks++;
    if (aif.rd_last !== 32'd15 || aif.rd_min !== 32'd15 ||
        aif.rd_max !== 32'd15 || aif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL single_stats got %0d/%0d/%0d/%0d want 15/15/15/1",
        aif.rd_last, aif.rd_min, aif.rd_max, aif.rd_runs);
    end
    step();
    checks++;
    if (aif.done[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got %b want 0", aif.done[0]);
    end
  endtask

  task automatic test_multi();
    a_run(1, 7);
    a_run(1, 3);
    a_run(1, 12);
    aif.rd_sel = 2'd1;
    #1;
    checks++;
    if (aif.rd_last !== 32'd12 || aif.rd_min !== 32'd3 ||
        aif.rd_max !== 32'd12 || aif.rd_runs !== 16'd3) begin
      errors++;
      $display("FAIL multi_ch1 got %0d/%0d/%0d/%0d want 12/3/12/3",
        aif.rd_last, aif.rd_min, aif.rd_max, aif.rd_runs);
    end
    aif.rd_sel = 2'd0;
    #1;
    checks++;
    if (aif.rd_last !== 32'd15 || aif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL multi_ch0 got %0d/%0d want 15/1",
        aif.rd_last, aif.rd_runs);
    end
    aif.rd_sel = 2'd2;
    #1;
    checks++;
    if (aif.rd_runs !== 16'd0 || aif.rd_min !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL multi_ch2 got runs=%0d min=%h want 0 ffffffff",
        aif.rd_runs, aif.rd_min);
    end
  endtask

  task automatic test_idle_stop();
    aif.stop[3] = 1'b1;
    step();
    aif.stop[3] = 1'b0;
    aif.rd_sel = 2'd3;
    #1;
    checks++;
    if (aif.busy[3] !== 1'b0 || aif.done[3] !== 1'b0 ||
        aif.rd_runs !== 16'd0 || aif.rd_last !== 32'd0) begin
      errors++;
      $display("FAIL idle_stop got busy=%b done=%b runs=%0d last=%0d want 0 0 0 0",
        aif.busy[3], aif.done[3], aif.rd_runs, aif.rd_last);
    end
  endtask

  task automatic test_start_stop_idle();
    aif.start[3] = 1'b1;
    aif.stop[3]  = 1'b1;
    step();
    aif.start[3] = 1'b0;
    aif.stop[3]  = 1'b0;
    aif.rd_sel = 2'd3;
    #1;
    checks++;
    if (aif.busy[3] !== 1'b1 || aif.done[3] !== 1'b0 ||
        aif.rd_runs !== 16'd0) begin
      errors++;
      $display("FAIL ss_idle got busy=%b done=%b runs=%0d want 1 0 0",
        aif.busy[3], aif.done[3], aif.rd_runs);
    end
    step();
    step();
    aif.start[3] = 1'b1;
    aif.stop[3]  = 1'b1;
    step();
    aif.start[3] = 1'b0;
    aif.stop[3]  = 1'b0;
    #1;
    checks++;
    if (aif.busy[3] !== 1'b0 || aif.done[3] !== 1'b1 ||
        aif.rd_last !== 32'd3 || aif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL ss_run got busy=%b done=%b last=%0d runs=%0d want 0 1 3 1",
        aif.busy[3], aif.done[3], aif.rd_last, aif.rd_runs);
    end
  endtask

  task automatic test_back_to_back();
    a_run(0, 5);
    a_run(0, 20);
    aif.rd_sel = 2'd0;
    #1;
    checks++;
    if (aif.rd_last !== 32'd20 || aif.rd_min !== 32'd5 ||
        aif.rd_max !== 32'd20 || aif.rd_runs !== 16'd3) begin
      errors++;
      $display("FAIL b2b got %0d/%0d/%0d/%0d want 20/5/20/3",
        aif.rd_last, aif.rd_min, aif.rd_max, aif.rd_runs);
    end
  endtask

  task automatic test_restart();
    aif.start[2] = 1'b1;
    dif.start[0] = 1'b1;
    step();
    aif.start[2] = 1'b0;
    dif.start[0] = 1'b0;
    repeat (7) step();
    aif.start[2] = 1'b1;
    dif.start[0] = 1'b1;
    step();
    aif.start[2] = 1'b0;
    dif.start[0] = 1'b0;
    checks++;
    if (dif.busy[0] !== 1'b1 || dif.done[0] !== 1'b0) begin
      errors++;
      $display("FAIL restart_nodone got busy=%b done=%b want 1 0",
        dif.busy[0], dif.done[0]);
    end
    repeat (3) step();
    aif.stop[2] = 1'b1;
    dif.stop[0] = 1'b1;
    step();
    aif.stop[2] = 1'b0;
    dif.stop[0] = 1'b0;
    aif.rd_sel = 2'd2;
    dif.rd_sel = 2'd0;
    #1;
    checks++;
    if (dif.rd_last !== 32'd4 || dif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL restart1 got last=%0d runs=%0d want 4 1",
        dif.rd_last, dif.rd_runs);
    end
    checks++;
    if (aif.rd_last !== 32'd12 || aif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL restart0 got last=%0d runs=%0d want 12 1",
        aif.rd_last, aif.rd_runs);
    end
  endtask

  task automatic test_tick_div();
    bif.rd_sel = 2'd0;
    b_run(149);
    #1;
    checks++;
    if (bif.rd_last !== 32'd2 || bif.done[0] !== 1'b1) begin
      errors++;
      $display("FAIL div_149 got last=%0d done=%b want 2 1",
        bif.rd_last, bif.done[0]);
    end
    b_run(150);
    #1;
    checks++;
    if (bif.rd_last !== 32'd3 || bif.rd_min !== 32'd2 ||
        bif.rd_max !== 32'd3 || bif.rd_runs !== 16'd2) begin
      errors++;
      $display("FAIL div_150 got %0d/%0d/%0d/%0d want 3/2/3/2",
        bif.rd_last, bif.rd_min, bif.rd_max, bif.rd_runs);
    end
  endtask

  task automatic test_saturate();
    cif.rd_sel = 2'd0;
    c_run(20);
    #1;
    checks++;
    if (cif.rd_last !== 4'd15 || cif.rd_max !== 4'd15 ||
        cif.rd_ovf !== 1'b1 || cif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL sat_20 got last=%0d max=%0d ovf=%b runs=%0d want 15 15 1 1",
        cif.rd_last, cif.rd_max, cif.rd_ovf, cif.rd_runs);
    end
    cif.clr[0] = 1'b1;
    step();
    cif.clr[0] = 1'b0;
    #1;
    checks++;
    if (cif.rd_ovf !== 1'b0 || cif.rd_runs !== 16'd0 ||
        cif.rd_last !== 4'd0 || cif.rd_min !== 4'hF) begin
      errors++;
      $display("FAIL sat_clr got ovf=%b runs=%0d last=%0d min=%0d want 0 0 0 15",
        cif.rd_ovf, cif.rd_runs, cif.rd_last, cif.rd_min);
    end
    c_run(5);
    #1;
    checks++;
    if (cif.rd_ovf !== 1'b0 || cif.rd_last !== 4'd5 ||
        cif.rd_min !== 4'd5 || cif.rd_runs !== 16'd1) begin
      errors++;
      $display("FAIL sat_after got ovf=%b last=%0d min=%0d runs=%0d want 0 5 5 1",
        cif.rd_ovf, cif.rd_last, cif.rd_min, cif.rd_runs);
    end
  endtask

  task automatic test_rst_mid();
    aif.start[0] = 1'b1;
    step();
    aif.start[0] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    aif.stop[0] = 1'b1;
    step();
    rst = 1'b0;
    aif.stop[0] = 1'b0;
    aif.rd_sel = 2'd0;
    #1;
    checks++;
    if (aif.busy !== 4'b0000 || aif.done !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_busy got busy=%b done=%b want 0000 0000",
        aif.busy, aif.done);
    end
    checks++;
    if (aif.rd_last !== 32'd0 || aif.rd_max !== 32'd0 ||
        aif.rd_min !== 32'hFFFF_FFFF || aif.rd_runs !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_stats got %0d/%h/%0d/%0d want 0/ffffffff/0/0",
        aif.rd_last, aif.rd_min, aif.rd_max, aif.rd_runs);
    end
    step();
    checks++;
    if (aif.done[0] !== 1'b0 || aif.busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got done=%b busy=%b want 0 0",
        aif.done[0], aif.busy[0]);
    end
  endtask

  initial begin
    aif.start = '0; aif.stop = '0; aif.clr = '0; aif.rd_sel = '0;
    bif.start = '0; bif.stop = '0; bif.clr = '0; bif.rd_sel = '0;
    cif.start = '0; cif.stop = '0; cif.clr = '0; cif.rd_sel = '0;
    dif.start = '0; dif.stop = '0; dif.clr = '0; dif.rd_sel = '0;
    test_reset();
    test_single();
    test_multi();
    test_idle_stop();
    test_start_stop_idle();
    test_back_to_back();
    test_restart();
    test_tick_div();
    test_saturate();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
